// File: rtl/spi_job_ctrl_if.sv
// spi_job_ctrl_if: SPI front-end, compute-core and READY pad signals of one job controller.
interface spi_job_ctrl_if #(
  parameter int JOB_BITS = 64,
  parameter int RESULT_W = 32
);
  logic spi0_sck_rise_in;
  logic spi0_sdi_in;
  logic spi0_cs_n_in;
  logic spi1_sck_rise_in;
  logic spi1_sdi_in;
  logic spi1_cs_n_in;
  logic spi1_sdo_out;
  logic [JOB_BITS-1:0] core_job_out;
  logic core_start_out;
  logic core_abort_out;
  logic core_done_in;
  logic [RESULT_W-1:0] core_result_in;
  logic ready_oe_out;
  logic [1:0] state_out;
  logic timeout_out;
  // master is the board environment (front-ends and core), slave is the controller
  modport master (
    output spi0_sck_rise_in, spi0_sdi_in, spi0_cs_n_in,
    output spi1_sck_rise_in, spi1_sdi_in, spi1_cs_n_in,
    output core_done_in, core_result_in,
    input spi1_sdo_out, core_job_out, core_start_out, core_abort_out,
    input ready_oe_out, state_out, timeout_out
  );
  modport slave (
    input spi0_sck_rise_in, spi0_sdi_in, spi0_cs_n_in,
    input spi1_sck_rise_in, spi1_sdi_in, spi1_cs_n_in,
    input core_done_in, core_result_in,
    output spi1_sdo_out, core_job_out, core_start_out, core_abort_out,
    output ready_oe_out, state_out, timeout_out
  );
endinterface

// File: rtl/spi_job_ctrl.sv
// spi_job_ctrl: sequences a compute core from SPI1 daisy-chained jobs and SPI0 broadcast commands.
module spi_job_ctrl #(
  parameter int JOB_BITS = 64,
  parameter int RESULT_W = 32,
  parameter int CMD_BITS = 8,
  parameter int TIMEOUT_CYCLES = 16777216
) (
  input logic clk_in,
  input logic reset_in,
  spi_job_ctrl_if.slave bus
);
  localparam int CW1 = $clog2(JOB_BITS);
  localparam int CW0 = $clog2(CMD_BITS + 2);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, LOADED, RUNNING, DONE} state_t;
  state_t state, state_n;
  logic cs0_prev, cs1_prev;
  logic [CMD_BITS-1:0] sr0;
  logic [CW0-1:0] cnt0;
  logic [JOB_BITS-1:0] sr1, job_reg;
  logic [CW1-1:0] cnt1;
  logic wrapped;
  logic [RESULT_W-1:0] result_reg;
  logic [WW-1:0] wd;
  logic timeout, start_q, abort_q, ready_q;
  logic start_d, abort_d, wd_fire, job_load, result_load;
  logic cs0_fall, cs0_rise, cs1_fall, cs1_rise, shift0, shift1;
  logic cmd_ok, abort_ev, start_ev, clear_ev, done_ev, wd_ev, frame_ev;

  assign cs0_fall = cs0_prev & ~bus.spi0_cs_n_in;
  assign cs0_rise = ~cs0_prev & bus.spi0_cs_n_in;
  assign cs1_fall = cs1_prev & ~bus.spi1_cs_n_in;
  assign cs1_rise = ~cs1_prev & bus.spi1_cs_n_in;
  assign shift0 = ~bus.spi0_cs_n_in & bus.spi0_sck_rise_in;
  assign shift1 = ~bus.spi1_cs_n_in & bus.spi1_sck_rise_in;
  assign cmd_ok = cs0_rise && cnt0 == CW0'(CMD_BITS);
  assign abort_ev = cmd_ok && sr0 == CMD_BITS'(8'h5A);
  assign start_ev = cmd_ok && sr0 == CMD_BITS'(8'hA5) && state == LOADED;
  assign clear_ev = cmd_ok && sr0 == CMD_BITS'(8'h3C);
  assign done_ev = state == RUNNING && bus.core_done_in;
  assign wd_ev = state == RUNNING && wd == WW'(TIMEOUT_CYCLES - 1);
  // a frame is whole only when the stride counter wrapped and landed back on zero
  assign frame_ev = cs1_rise && wrapped && cnt1 == '0 && state != RUNNING;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cs0_prev <= 1'b1;
      cs1_prev <= 1'b1;
      sr0 <= '0;
      cnt0 <= '0;
      sr1 <= '0;
      cnt1 <= '0;
      wrapped <= 1'b0;
    end else begin
      cs0_prev <= bus.spi0_cs_n_in;
      cs1_prev <= bus.spi1_cs_n_in;
      if (cs0_fall) cnt0 <= '0;
      else if (shift0) begin
        sr0 <= {sr0[CMD_BITS-2:0], bus.spi0_sdi_in};
        cnt0 <= &cnt0 ? cnt0 : cnt0 + 1'b1;
      end
      if (cs1_fall && state == DONE) sr1 <= JOB_BITS'(result_reg) << (JOB_BITS - RESULT_W);
      else if (shift1) sr1 <= {sr1[JOB_BITS-2:0], bus.spi1_sdi_in};
      if (cs1_fall) begin
        cnt1 <= '0;
        wrapped <= 1'b0;
      end else if (shift1) begin
        cnt1 <= cnt1 + 1'b1;
        wrapped <= wrapped | (&cnt1);
      end
    end
  end

  always_ff @(posedge clk_in) state <= reset_in ? IDLE : state_n;

  always_comb
    state_n = abort_ev ? IDLE : done_ev ? DONE : wd_ev ? IDLE :
              start_ev ? RUNNING : frame_ev ? LOADED : state;

  always_comb begin
    start_d = start_ev && state_n == RUNNING;
    abort_d = state == RUNNING && state_n == IDLE;
    wd_fire = abort_d && !abort_ev;
    job_load = frame_ev && state_n == LOADED;
    result_load = done_ev && state_n == DONE;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      job_reg <= '0;
      result_reg <= '0;
      wd <= '0;
      timeout <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      start_q <= start_d;
      abort_q <= abort_d;
      ready_q <= state_n == DONE;
      timeout <= wd_fire ? 1'b1 : (start_d || clear_ev) ? 1'b0 : timeout;
      wd <= start_d ? '0 : state == RUNNING ? wd + 1'b1 : wd;
      if (job_load) job_reg <= sr1;
      if (result_load) result_reg <= bus.core_result_in;
    end
  end

  assign bus.spi1_sdo_out = sr1[JOB_BITS-1];
  assign bus.core_job_out = job_reg;
  assign bus.core_start_out = start_q;
  assign bus.core_abort_out = abort_q;
  assign bus.ready_oe_out = ready_q;
  assign bus.state_out = state;
  assign bus.timeout_out = timeout;
endmodule
